ethernet_receive_que_slot: RTL and testbench

One receive queue slot: buffers the byte stream that the Ethernet packet parser steers into it, and commits or discards each frame on the parser's CRC verdict. Committed frames are replayed to the switch fabric as a byte stream with an end-of-frame marker and a valid/ready handshake. `receive_slot_enable` back-pressures the parser so that it only selects this slot when a maximum-size frame is guaranteed to fit.

---
 rtl/ethernet_receive_que_slot.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ethernet_receive_que_slot.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_receive_que_slot.sv
// ethernet_receive_que_slot
//
// One receive queue slot. The packet parser steers frame bytes into a byte
// RAM. Each frame is committed on good_packet or rolled back on bad_packet.
// Committed frames are replayed to the switch fabric as a byte stream with an
// end-of-frame marker.
//
// Optional feature macro: ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN
//   defined   : the 4 FCS bytes are stripped on commit. Frames of 4 bytes or
//               fewer are dropped.
//   undefined : frames are stored and replayed byte-exact.
//
// Ports
//   clock, reset_n        rising-edge clock; asynchronous active-low reset
//   packet_data[7:0]      frame byte from the parser
//   packet_data_valid     packet_data belongs to this slot this cycle
//   good_packet           1-cycle pulse: the current frame passed CRC
//   bad_packet            1-cycle pulse: the current frame failed CRC
//   receive_slot_enable   registered: a full MAX_FRAME_BYTES frame will fit
//   read_data[7:0]        output frame byte
//   read_valid            read_data is valid
//   read_last             last byte of the frame (qualified by read_valid)
//   read_ready            consumer accepts the byte
//   frame_count           committed frames not yet fully read
//   dropped_frames[15:0]  saturating count of discarded frames
//   read_state[1:0]       read FSM state (debug visibility)
//
// Handshake: a byte transfers on every rising edge where read_valid and
// read_ready are both 1. Once read_valid is raised, read_data, read_valid and
// read_last are held unchanged until that transfer happens. read_valid does
// not depend on read_ready.

module ethernet_receive_que_slot #(
   parameter int DEPTH_BYTES     = 4096,
   parameter int MAX_FRAME_BYTES = 1522,
   parameter int LENGTH_SLOTS    = 8
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [7:0]                      packet_data,
   input  logic                            packet_data_valid,
   input  logic                            good_packet,
   input  logic                            bad_packet,
   output logic                            receive_slot_enable,
   output logic [7:0]                      read_data,
   output logic                            read_valid,
   output logic                            read_last,
   input  logic                            read_ready,
   output logic [$clog2(LENGTH_SLOTS):0]   frame_count,
   output logic [15:0]                     dropped_frames,
   output logic [1:0]                      read_state
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(MAX_FRAME_BYTES + 1);
   localparam int FW = $clog2(LENGTH_SLOTS);

`ifdef ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN
   localparam int FCS_BYTES = 4;
   localparam int MIN_BYTES = 5;
`else
   localparam int FCS_BYTES = 0;
   localparam int MIN_BYTES = 1;
`endif

   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_BYTES);
   localparam logic [PW-1:0] MAX_P   = PW'(MAX_FRAME_BYTES);
   localparam logic [PW-1:0] MIN_P   = PW'(MIN_BYTES);
   localparam logic [PW-1:0] FCS_P   = PW'(FCS_BYTES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_STREAM = 2'd2
   } read_state_t;

   // ---------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------
   logic [7:0]    byte_ram   [DEPTH_BYTES];
   logic [LW-1:0] length_ram [LENGTH_SLOTS];

   // ---------------------------------------------------------------
   // Pointers and state
   // ---------------------------------------------------------------
   logic [PW-1:0] write_pointer;
   logic [PW-1:0] frame_start;
   logic [PW-1:0] read_pointer;
   logic          overflow;
   logic [FW:0]   len_wr_ptr;
   logic [FW:0]   len_rd_ptr;
   read_state_t   state;
   logic [LW-1:0] remaining;

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic [PW-1:0] frame_len;
   logic [PW-1:0] used_space;
   logic [PW-1:0] free_space;
   logic [FW:0]   len_count;
   logic          len_full;
   logic          len_empty;
   logic          verdict;
   logic          reject;
   logic          commit;
   logic [PW-1:0] commit_end;
   logic [LW-1:0] commit_len;
   logic [PW-1:0] next_base;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          ram_re;
   logic          last_handshake;

   assign frame_len  = write_pointer - frame_start;
   assign used_space = write_pointer - read_pointer;
   assign free_space = DEPTH_P - used_space;
   assign len_count  = len_wr_ptr - len_rd_ptr;
   assign len_full   = (len_count == (FW+1)'(LENGTH_SLOTS));
   assign len_empty  = (len_wr_ptr == len_rd_ptr);

   // A simultaneous good and bad verdict counts as bad. A commit into a full
   // length FIFO cannot be recorded, so that frame is dropped as well.
   assign verdict    = good_packet | bad_packet;
   assign reject     = bad_packet | overflow | (frame_len < MIN_P) | len_full;
   assign commit     = verdict & ~reject;

   // With FCS stripping, the committed end sits 4 bytes before the write
   // pointer, so the next frame overwrites the FCS.
   assign commit_end = write_pointer - FCS_P;
   assign commit_len = frame_len[LW-1:0] - LW'(FCS_BYTES);

   // The position where the next frame starts after this cycle's verdict.
   assign next_base  = commit ? commit_end : frame_start;

   // A byte that arrives with a verdict is the first byte of the next frame.
   // It is written at the post-verdict base.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = write_pointer[AW-1:0];
      if (verdict) begin
         mem_we    = packet_data_valid;
         mem_waddr = next_base[AW-1:0];
      end else begin
         mem_we    = packet_data_valid & (frame_len < MAX_P);
         mem_waddr = write_pointer[AW-1:0];
      end
   end

   assign last_handshake = read_valid & read_ready & read_last;

   // The RAM output register holds its value unless a new byte is fetched.
   // The fetch is for the first byte in S_LOAD, or for the next byte when
   // the current non-last byte is accepted.
   assign ram_re = (state == S_LOAD) |
                   ((state == S_STREAM) & read_valid & read_ready & ~read_last);

   assign read_state = state;

   // ---------------------------------------------------------------
   // Byte RAM write port
   // ---------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (mem_we)
         byte_ram[mem_waddr] <= packet_data;
   end

   // ---------------------------------------------------------------
   // Byte RAM read port (1-cycle latency, held when not fetching)
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         read_data <= 8'd0;
      else if (ram_re)
         read_data <= byte_ram[read_pointer[AW-1:0]];
   end

   // ---------------------------------------------------------------
   // Length FIFO write port
   // ---------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (commit)
         length_ram[len_wr_ptr[FW-1:0]] <= commit_len;
   end

   // ---------------------------------------------------------------
   // Write side: frame accumulation, commit and rollback
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_pointer  <= '0;
         frame_start    <= '0;
         overflow       <= 1'b0;
         len_wr_ptr     <= '0;
         dropped_frames <= 16'd0;
      end else begin
         if (verdict) begin
            frame_start   <= next_base;
            write_pointer <= next_base + {{(PW-1){1'b0}}, packet_data_valid};
            overflow      <= 1'b0;
            if (commit)
               len_wr_ptr <= len_wr_ptr + 1'b1;
            else if (dropped_frames != 16'hFFFF)
               dropped_frames <= dropped_frames + 16'd1;
         end else if (packet_data_valid) begin
            if (frame_len < MAX_P)
               write_pointer <= write_pointer + 1'b1;
            else
               overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Committed-frame counter: covers frames waiting in the length FIFO
   // plus the frame being streamed
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         frame_count <= '0;
      else if (commit && !last_handshake)
         frame_count <= frame_count + 1'b1;
      else if (!commit && last_handshake)
         frame_count <= frame_count - 1'b1;
   end

   // ---------------------------------------------------------------
   // Slot enable: room for one more maximum-size frame and one more length
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         receive_slot_enable <= 1'b0;
      else
         receive_slot_enable <= (free_space >= MAX_P) & ~len_full;
   end

   // ---------------------------------------------------------------
   // Read FSM
   // The read pointer advances when a byte is fetched into the output
   // register. That RAM location is then free to be overwritten, even while
   // the byte still waits for its handshake.
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         read_valid   <= 1'b0;
         read_last    <= 1'b0;
         remaining    <= '0;
         read_pointer <= '0;
         len_rd_ptr   <= '0;
      end else begin
         if (ram_re)
            read_pointer <= read_pointer + 1'b1;
         case (state)
            S_IDLE: begin
               if (!len_empty)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               remaining  <= length_ram[len_rd_ptr[FW-1:0]];
               read_last  <= (length_ram[len_rd_ptr[FW-1:0]] == LW'(1));
               read_valid <= 1'b1;
               len_rd_ptr <= len_rd_ptr + 1'b1;
               state      <= S_STREAM;
            end
            S_STREAM: begin
               if (read_valid && read_ready) begin
                  if (read_last) begin
                     read_valid <= 1'b0;
                     read_last  <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     remaining <= remaining - 1'b1;
                     read_last <= (remaining == LW'(2));
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ethernet_receive_que_slot.sv
`timescale 1ns/1ps
module tb_ethernet_receive_que_slot;

`ifdef ETHERNET_RECEIVE_QUE_SLOT_STRIP_FCS_EN
   localparam int   FCS   = 4;
   localparam logic STRIP = 1'b1;
`else
   localparam int   FCS   = 0;
   localparam logic STRIP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  packet_data = 8'd0;
   logic        packet_data_valid = 1'b0;
   logic        good_packet = 1'b0;
   logic        bad_packet = 1'b0;
   logic        receive_slot_enable;
   logic [7:0]  read_data;
   logic        read_valid;
   logic        read_last;
   logic        read_ready = 1'b0;
   logic [3:0]  frame_count;
   logic [15:0] dropped_frames;
   logic [1:0]  read_state;

   always #5 clock = ~clock;

   ethernet_receive_que_slot dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .packet_data         (packet_data),
      .packet_data_valid   (packet_data_valid),
      .good_packet         (good_packet),
      .bad_packet          (bad_packet),
      .receive_slot_enable (receive_slot_enable),
      .read_data           (read_data),
      .read_valid          (read_valid),
      .read_last           (read_last),
      .read_ready          (read_ready),
      .frame_count         (frame_count),
      .dropped_frames      (dropped_frames),
      .read_state          (read_state)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   int         exp_dropped = 0;
   int         frames_seen = 0;
   int         ready_mode = 1;   // 0: hold low, 1: always high, 2: random

   typedef struct {
      int         len;
      logic [7:0] base;
      logic       good;
      logic       bad;
      logic       exp_drop;
   } frame_vec_t;

   frame_vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_expected(input int len, input logic [7:0] base);
      for (int i = 0; i < len - FCS; i++)
         exp_q.push_back({(i == len - FCS - 1), base + 8'(i)});
   endtask

   task automatic send_frame(input int len, input logic [7:0] base, input logic good,
                             input logic bad, input logic exp_drop);
      for (int i = 0; i < len; i++) begin
         tick();
         packet_data_valid = 1'b1;
         packet_data       = base + 8'(i);
      end
      tick();
      packet_data_valid = 1'b0;
      good_packet       = good;
      bad_packet        = bad;
      if (exp_drop) exp_dropped++;
      else push_expected(len, base);
      tick();
      good_packet = 1'b0;
      bad_packet  = 1'b0;
      check("dropped_after_verdict", dropped_frames, exp_dropped);
   endtask

   // Frame A's verdict shares a cycle with frame B's first byte.
   task automatic send_pair(input int len_a, input logic [7:0] base_a, input logic good_a,
                            input int len_b, input logic [7:0] base_b);
      for (int i = 0; i < len_a; i++) begin
         tick();
         packet_data_valid = 1'b1;
         packet_data       = base_a + 8'(i);
      end
      tick();
      good_packet       = good_a;
      bad_packet        = ~good_a;
      packet_data_valid = 1'b1;
      packet_data       = base_b;
      if (good_a) push_expected(len_a, base_a);
      else exp_dropped++;
      for (int i = 1; i < len_b; i++) begin
         tick();
         good_packet       = 1'b0;
         bad_packet        = 1'b0;
         packet_data_valid = 1'b1;
         packet_data       = base_b + 8'(i);
      end
      tick();
      packet_data_valid = 1'b0;
      good_packet       = 1'b1;
      bad_packet        = 1'b0;
      push_expected(len_b, base_b);
      tick();
      good_packet = 1'b0;
      check("dropped_after_pair", dropped_frames, exp_dropped);
   endtask

   task automatic wait_enable();
      int n = 0;
      while (!receive_slot_enable && n < 20000) begin
         tick();
         n++;
      end
      check("enable_wait", receive_slot_enable, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || frame_count != 0) && n < 40000) begin
         tick();
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_frame_count", frame_count, 0);
   endtask

   // ---------------- ready driver ----------------
   initial begin
      forever begin
         @(posedge clock);
         #2;
         case (ready_mode)
            0:       read_ready = 1'b0;
            1:       read_ready = 1'b1;
            default: read_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- output monitor / scoreboard ----------------
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   initial begin
      logic [8:0] exp;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("hold_stable", {read_valid, read_last, read_data}, {1'b1, prev_last, prev_data});
            if (read_valid && read_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %0h expected none", {read_last, read_data});
               end else begin
                  exp = exp_q.pop_front();
                  check("stream_byte", {read_last, read_data}, exp);
               end
               if (read_last) frames_seen++;
            end
            prev_stall = read_valid && !read_ready;
            prev_data  = read_data;
            prev_last  = read_last;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #900us;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int fs;
      int n;

      vecs[0]  = '{64,   8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{100,  8'h80, 1'b0, 1'b1, 1'b1};
      vecs[2]  = '{10,   8'h40, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1,    8'hA5, 1'b1, 1'b0, STRIP};
      vecs[4]  = '{0,    8'h00, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{4,    8'h10, 1'b1, 1'b0, STRIP};
      vecs[6]  = '{5,    8'h20, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{30,   8'h33, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1522, 8'h07, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1523, 8'h09, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{200,  8'hF0, 1'b1, 1'b0, 1'b0};

      // Reset values
      tick();
      tick();
      check("reset_enable", receive_slot_enable, 0);
      check("reset_valid", read_valid, 0);
      check("reset_last", read_last, 0);
      check("reset_data", read_data, 0);
      check("reset_frame_count", frame_count, 0);
      check("reset_dropped", dropped_frames, 0);
      check("reset_state", read_state, 0);
      reset_n = 1'b1;
      tick();
      check("enable_after_release", receive_slot_enable, 1);

      // Good frame with commit-to-valid latency
      ready_mode = 1;
      send_frame(64, 8'h00, 1'b1, 1'b0, 1'b0);
      check("lat_cycle1_valid", read_valid, 0);
      check("lat_cycle1_frame_count", frame_count, 1);
      tick();
      check("lat_cycle2_valid", read_valid, 0);
      check("lat_cycle2_state_load", read_state, 1);
      tick();
      check("lat_cycle3_valid", read_valid, 1);
      check("lat_cycle3_data", read_data, 8'h00);
      wait_drain();

      // Table-driven frames with concurrent draining
      for (int v = 0; v < 11; v++) begin
         wait_enable();
         send_frame(vecs[v].len, vecs[v].base, vecs[v].good, vecs[v].bad, vecs[v].exp_drop);
      end
      wait_drain();

      // Verdict and next frame's first byte in the same cycle
      send_pair(20, 8'h90, 1'b1, 12, 8'hC0);
      send_pair(25, 8'h50, 1'b0, 9, 8'hD0);
      wait_drain();

      // Back-pressure: fill with maximum-size frames while stalled
      ready_mode = 0;
      wait_enable();
      send_frame(1522, 8'h11, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check("bp_enable_after_one", receive_slot_enable, 1);
      send_frame(1522, 8'h22, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check("bp_enable_low_when_full", receive_slot_enable, 0);
      check("bp_frame_count", frame_count, 2);
      check("bp_valid_stalled", read_valid, 1);
      fs = frames_seen;
      ready_mode = 1;
      n = 0;
      while (frames_seen == fs && n < 5000) begin
         tick();
         n++;
      end
      check("bp_first_frame_drained", frames_seen, fs + 1);
      tick();
      tick();
      check("bp_enable_reasserted", receive_slot_enable, 1);
      wait_drain();

      // Overflow frame, then an intact frame
      send_frame(1600, 8'h55, 1'b1, 1'b0, 1'b1);
      check("ovf_frame_count", frame_count, 0);
      wait_enable();
      send_frame(64, 8'h60, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // Random stalls across the pointer wrap
      ready_mode = 2;
      for (int f = 0; f < 3; f++) begin
         wait_enable();
         send_frame(1400, 8'(8'h17 * f + 8'h03), 1'b1, 1'b0, 1'b0);
      end
      wait_drain();

      // Reset in the middle of a read
      ready_mode = 0;
      wait_enable();
      send_frame(64, 8'h70, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (!read_valid && n < 20) begin
         tick();
         n++;
      end
      check("mid_read_streaming", read_valid, 1);
      ready_mode = 1;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("rst_mid_valid", read_valid, 0);
      check("rst_mid_last", read_last, 0);
      check("rst_mid_data", read_data, 0);
      check("rst_mid_frame_count", frame_count, 0);
      check("rst_mid_enable", receive_slot_enable, 0);
      check("rst_mid_dropped", dropped_frames, 0);
      exp_q.delete();
      exp_dropped = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_enable_after_release", receive_slot_enable, 1);
      send_frame(20, 8'hE0, 1'b1, 1'b0, 1'b0);
      wait_drain();

      check("final_dropped", dropped_frames, exp_dropped);
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
